// File: rtl/fir_pkg.sv
// Constants shared between the pipelined FIR and the blocks that consume its output.
package fir_pkg;

   localparam int FIR_TAPS   = 102;
   localparam int FIR_OUT_W  = 64;
   localparam int FIR_COEF_W = 32;
   localparam int FIR_IN_W   = 16;

endpackage

// File: rtl/fir_out_requant_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a write to a full FIFO lands only if a read
// frees a slot on the same edge, otherwise it is dropped and memory is untouched.
module sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         wr_fire;
   logic         rd_fire;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;

   // Head is forced to zero when empty so the sink never sees stale data.
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      rd_fire  = rd_en && !empty;
      wr_fire  = wr_en && (!full || rd_fire);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: drops warm-up samples, rounds/shifts, saturates to OUT_W and
// buffers results for a sink that may stall.
module fir_out_requant
   import fir_pkg::*;
#(
   parameter int IN_W   = FIR_OUT_W,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 0,
   parameter int WARMUP = FIR_TAPS,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_en,
   input  logic [IN_W-1:0]          in_data,
   input  logic                     clr_flags,
   output logic [OUT_W-1:0]         m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     warm,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     sat_flag,
   output logic                     ovf_flag
);

   localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               s1_valid_q, s1_valid_d;
   logic signed [IN_W:0] s1_data_q, s1_data_d;
   logic               sat_q, sat_d;
   logic               ovf_q, ovf_d;
   logic signed [IN_W:0] r_w;
   logic [OUT_W-1:0]   sat_val;
   logic               clipped;
   logic               rd_en;
   logic               fifo_full;
   logic               fifo_empty;

   assign warm = (cnt_q == CNT_W'(WARMUP));

   // One extra bit of headroom so the rounding add never wraps near full scale.
   if (SHIFT > 0) begin : g_round
      localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
      logic signed [IN_W:0] sum_w;
      assign sum_w = {in_data[IN_W-1], in_data} + RND;
      assign r_w   = sum_w >>> SHIFT;
   end else begin : g_pass
      assign r_w = {in_data[IN_W-1], in_data};
   end

   always_comb begin
      cnt_d      = cnt_q;
      s1_valid_d = in_en && warm;
      s1_data_d  = r_w;
      if (in_en && !warm) cnt_d = cnt_q + CNT_W'(1);
   end

   always_comb begin
      sat_val = s1_data_q[OUT_W-1:0];
      clipped = 1'b0;
      if (s1_data_q > SAT_MAX) begin
         sat_val = SAT_MAX[OUT_W-1:0];
         clipped = 1'b1;
      end else if (s1_data_q < SAT_MIN) begin
         sat_val = SAT_MIN[OUT_W-1:0];
         clipped = 1'b1;
      end
   end

   // Handshake: a sample transfers on any edge where m_valid && m_ready; m_data is held
   // stable while m_valid is high and m_ready is low.
   assign m_valid = !fifo_empty;
   assign rd_en   = m_valid && m_ready;

   // A set event in the same cycle as clr_flags wins.
   always_comb begin
      sat_d = sat_q;
      ovf_d = ovf_q;
      if (clr_flags) begin
         sat_d = 1'b0;
         ovf_d = 1'b0;
      end
      if (s1_valid_q && clipped)                sat_d = 1'b1;
      if (s1_valid_q && fifo_full && !rd_en)    ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         sat_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         sat_q      <= sat_d;
         ovf_q      <= ovf_d;
      end
   end

   assign sat_flag = sat_q;
   assign ovf_flag = ovf_q;

   sync_fifo #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (s1_valid_q),
      .wr_data (sat_val),
      .rd_en   (rd_en),
      .rd_data (m_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: default instance plus a SHIFT=2 instance for rounding.
module tb_fir_out_requant;

   localparam int LVL_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              in_en, clr_flags, m_ready;
   logic [63:0]       in_data;
   logic [15:0]       m_data;
   logic              m_valid, warm, sat_flag, ovf_flag;
   logic [LVL_W-1:0]  level;

   logic              in2_en, clr2_flags, m2_ready;
   logic [63:0]       in2_data;
   logic [15:0]       m2_data;
   logic              m2_valid, warm2, sat2_flag, ovf2_flag;
   logic [LVL_W-1:0]  level2;

   fir_out_requant u_dut (
      .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data), .clr_flags(clr_flags),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .warm(warm), .level(level),
      .sat_flag(sat_flag), .ovf_flag(ovf_flag)
   );

   fir_out_requant #(.SHIFT(2), .WARMUP(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_en(in2_en), .in_data(in2_data), .clr_flags(clr2_flags),
      .m_data(m2_data), .m_valid(m2_valid), .m_ready(m2_ready), .warm(warm2), .level(level2),
      .sat_flag(sat2_flag), .ovf_flag(ovf2_flag)
   );

   typedef struct {
      logic [63:0] din;
      logic [15:0] dout;
      logic        sat;
      logic        clr;
   } vec_t;

   vec_t        t1[12];
   vec_t        t2[11];
   logic [63:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One isolated sample through an idle pipeline with the sink always ready.
   task automatic apply_vec(input int sel, input vec_t v, input string nm);
      if (v.clr) begin
         if (sel == 1) clr_flags = 1'b1; else clr2_flags = 1'b1;
         step();
         clr_flags = 1'b0; clr2_flags = 1'b0;
         check({nm, "_clr_sat"}, (sel == 1) ? sat_flag : sat2_flag, 0);
      end
      if (sel == 1) begin in_en = 1'b1; in_data = v.din; end
      else begin in2_en = 1'b1; in2_data = v.din; end
      step();
      in_en = 1'b0; in2_en = 1'b0;
      check({nm, "_valid_k1"}, (sel == 1) ? m_valid : m2_valid, 0);
      step();
      check({nm, "_valid_k2"}, (sel == 1) ? m_valid : m2_valid, 1);
      check({nm, "_data"}, (sel == 1) ? m_data : m2_data, v.dout);
      check({nm, "_sat"}, (sel == 1) ? sat_flag : sat2_flag, v.sat);
      step();
      check({nm, "_level"}, (sel == 1) ? level : level2, 0);
   endtask

   task automatic warmup_and_first(input string nm, input logic [15:0] first);
      int viol;
      viol = 0;
      for (int i = 0; i < 102; i++) begin
         in_en = 1'b1; in_data = 64'd1000;
         if (i == 101) check({nm, "_warm_before_last"}, warm, 0);
         step();
         if (m_valid) viol++;
      end
      check({nm, "_no_valid_in_warmup"}, viol, 0);
      check({nm, "_warm_after"}, warm, 1);
      in_data = 64'(first);
      step();
      in_en = 1'b0;
      check({nm, "_first_k1"}, m_valid, 0);
      step();
      check({nm, "_first_k2_valid"}, m_valid, 1);
      check({nm, "_first_k2_data"}, m_data, first);
      step();
      check({nm, "_first_drained"}, level, 0);
   endtask

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      t1[0]  = '{64'd100,       16'h0064, 1'b0, 1'b0};
      t1[1]  = '{-64'sd100,     16'hFF9C, 1'b0, 1'b0};
      t1[2]  = '{64'd32767,     16'h7FFF, 1'b0, 1'b0};
      t1[3]  = '{-64'sd32768,   16'h8000, 1'b0, 1'b0};
      t1[4]  = '{64'd40000,     16'h7FFF, 1'b1, 1'b0};
      t1[5]  = '{-64'sd40000,   16'h8000, 1'b1, 1'b0};
      t1[6]  = '{64'd32767,     16'h7FFF, 1'b1, 1'b0};
      t1[7]  = '{64'h7FFF_FFFF_FFFF_FFFF, 16'h7FFF, 1'b1, 1'b0};
      t1[8]  = '{64'd500,       16'h01F4, 1'b0, 1'b1};
      t1[9]  = '{64'h8000_0000_0000_0000, 16'h8000, 1'b1, 1'b0};
      t1[10] = '{64'd32768,     16'h7FFF, 1'b1, 1'b1};
      t1[11] = '{-64'sd32769,   16'h8000, 1'b1, 1'b0};

      t2[0]  = '{64'd6,         16'h0002, 1'b0, 1'b0};
      t2[1]  = '{64'd5,         16'h0001, 1'b0, 1'b0};
      t2[2]  = '{-64'sd6,       16'hFFFF, 1'b0, 1'b0};
      t2[3]  = '{-64'sd7,       16'hFFFE, 1'b0, 1'b0};
      t2[4]  = '{-64'sd2,       16'h0000, 1'b0, 1'b0};
      t2[5]  = '{-64'sd3,       16'hFFFF, 1'b0, 1'b0};
      t2[6]  = '{64'd2,         16'h0001, 1'b0, 1'b0};
      t2[7]  = '{64'd131069,    16'h7FFF, 1'b0, 1'b0};
      t2[8]  = '{64'd131070,    16'h7FFF, 1'b1, 1'b0};
      t2[9]  = '{64'h7FFF_FFFF_FFFF_FFFF, 16'h7FFF, 1'b1, 1'b0};
      t2[10] = '{64'h8000_0000_0000_0000, 16'h8000, 1'b1, 1'b0};

      rst = 1'b1;
      in_en = 1'b0; in_data = '0; clr_flags = 1'b0; m_ready = 1'b0;
      in2_en = 1'b0; in2_data = '0; clr2_flags = 1'b0; m2_ready = 1'b1;

      // Reset values
      @(negedge clk);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_level", level, 0);
      check("rst_warm", warm, 0);
      check("rst_sat", sat_flag, 0);
      check("rst_ovf", ovf_flag, 0);
      rst = 1'b0;
      m_ready = 1'b1;

      warmup_and_first("warmup", 16'd5);

      for (int i = 0; i < 12; i++) apply_vec(1, t1[i], $sformatf("sat_vec%0d", i));

      // clr_flags coincident with a clipped sample reaching the saturate stage
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("clr_before_coincident", sat_flag, 0);
      in_en = 1'b1; in_data = 64'd50000;
      step();
      in_en = 1'b0; clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("sat_set_wins", sat_flag, 1);
      check("sat_set_wins_data", m_data, 16'h7FFF);
      step();
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;

      // Backpressure and overflow
      m_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         in_en = 1'b1; in_data = 64'(i);
         if (exp_q.size() < 8) exp_q.push_back(64'(i));
         step();
      end
      in_en = 1'b0;
      step();
      step();
      check("bp_level", level, 8);
      check("bp_ovf", ovf_flag, 1);
      check("bp_valid", m_valid, 1);
      check("bp_sat", sat_flag, 0);
      check("bp_hold_data", m_data, 1);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bp_out%0d", i), m_data, exp_q.pop_front());
         step();
      end
      check("bp_drained_level", level, 0);
      check("bp_drained_valid", m_valid, 0);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("ovf_cleared", ovf_flag, 0);

      // Full FIFO with simultaneous read and write
      m_ready = 1'b0;
      for (int i = 101; i <= 108; i++) begin
         in_en = 1'b1; in_data = 64'(i);
         exp_q.push_back(64'(i));
         step();
      end
      in_en = 1'b0;
      step();
      step();
      check("rw_fill_level", level, 8);
      in_en = 1'b1; in_data = 64'd109;
      exp_q.push_back(64'd109);
      step();
      for (int k = 1; k <= 5; k++) begin
         m_ready = 1'b1;
         if (k <= 4) begin
            in_en = 1'b1; in_data = 64'(109 + k);
            exp_q.push_back(64'(109 + k));
         end else begin
            in_en = 1'b0;
         end
         check($sformatf("rw_level%0d", k), level, 8);
         check($sformatf("rw_data%0d", k), m_data, exp_q.pop_front());
         step();
      end
      m_ready = 1'b0;
      check("rw_level_after", level, 8);
      check("rw_ovf", ovf_flag, 0);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("rw_drain%0d", i), m_data, exp_q.pop_front());
         step();
      end
      check("rw_drained", level, 0);

      // Reset mid-stream
      m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         in_en = 1'b1; in_data = 64'(i);
         step();
      end
      in_en = 1'b0;
      step();
      step();
      check("mid_level_before", level, 5);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", m_valid, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_warm", warm, 0);
      check("mid_rst_data", m_data, 0);
      @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      check("mid_warm2_low", warm2, 0);
      warmup_and_first("rewarm", 16'd77);

      // SHIFT=2 instance: two warm-up samples, then rounding vectors
      for (int i = 0; i < 2; i++) begin
         in2_en = 1'b1; in2_data = 64'd9;
         step();
      end
      in2_en = 1'b0;
      check("r2_warm", warm2, 1);
      check("r2_no_output", m2_valid, 0);
      for (int i = 0; i < 11; i++) apply_vec(2, t2[i], $sformatf("rnd_vec%0d", i));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
